dcache_mem_ctrl: RTL and testbench
==================================

Name: dcache_mem_ctrl

Overview:
Memory-side initiator for the data cache: accepts one miss request at a time and drives the dmem port of the shared 128-bit line memory. A dirty victim is written back first, then the missing line is fetched. The block returns the fill line to the cache and pulses a done strobe. It sits between the dcache miss path and the memory's in_dmem_*/out_dmem_* port.

Parameters:
ADDR_W, 32, byte address width
LINE_W, 128, line width in bits; lines are 16-byte aligned
TIMEOUT_CYCLES, 64, watchdog limit per memory transaction (only used with MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
req_valid  in  1  cache presents a miss
req_ready  out  1  controller can accept a request (high only in IDLE)
req_addr  in  ADDR_W  miss byte address
req_dirty  in  1  victim line must be written back
req_victim_addr  in  ADDR_W  victim line byte address
req_victim_data  in  LINE_W  victim line data
fill_valid  out  1  one-cycle strobe: fill_data/fill_addr valid
fill_addr  out  ADDR_W  line-aligned address of the fill
fill_data  out  LINE_W  fetched line
mem_read_en  out  1  to in_dmem_read_en
mem_write_en  out  1  to in_dmem_write_en
mem_addr  out  ADDR_W  to in_dmem_addr
mem_write_data  out  LINE_W  to in_dmem_write_data
mem_read_data  in  LINE_W  from out_dmem_read_data
mem_ready  in  1  from out_dmem_ready (one-cycle pulse)
mem_err  out  1  sticky timeout flag (constant 0 without MEM_TIMEOUT_EN)

Behaviour:
- Reset is synchronous: when reset==0 at a clk edge, all outputs are forced to 0, the FSM goes to IDLE, and the latched request is cleared.
- A request is accepted on an edge where req_valid && req_ready. At that edge all req_* fields are latched. Addresses are aligned with [3:0] forced to 0.
- FSM states:
  - IDLE: req_ready=1. On accept, go to WB_REQ if req_dirty, otherwise go to RD_REQ.
  - WB_REQ: mem_write_en=1 for exactly one cycle; mem_addr=victim addr; mem_write_data=victim data. Next state WB_WAIT.
  - WB_WAIT: enables are 0; mem_addr and mem_write_data are held stable. The memory samples them late, so they must not change until mem_ready. On mem_ready, go to RD_REQ.
  - RD_REQ: mem_read_en=1 for one cycle; mem_addr=miss addr. Next state RD_WAIT.
  - RD_WAIT: mem_addr is held. On mem_ready, capture mem_read_data into fill_data and go to RESP.
  - RESP: fill_valid=1 for one cycle, with fill_addr=miss addr. Next state IDLE.
- Enables are registered, single-cycle pulses and are never high in WAIT states. This prevents the responder from re-triggering when it returns to IDLE.
- mem_read_en and mem_write_en are never high together.
- mem_ready seen outside WB_WAIT or RD_WAIT is ignored.
- Latency with a memory that asserts ready N cycles after sampling an enable:
  - clean miss: accept -> fill_valid takes N+3 edges;
  - dirty miss: 2N+5 edges.
  - With the 10-cycle memory: 13 and 25 edges.
- fill_data holds its value until the next fill capture. req_ready=0 from accept until the RESP->IDLE edge, so back-to-back requests are spaced by at least one IDLE cycle.
- Reset mid-transaction: the FSM aborts to IDLE and no fill_valid is produced. Memory-side recovery is the system's responsibility, because the memory resets independently.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to WB_WAIT or RD_WAIT and increments each cycle in those states.
  - Reaching TIMEOUT_CYCLES without mem_ready sets mem_err (sticky until reset), and the FSM goes to RESP.
  - In RESP, fill_valid pulses with fill_data=0.
- Without the macro: no counter exists, mem_err is tied 0, and WAIT states wait indefinitely.

Decomposition:
- Shared package dcache_pkg holds:
  - the state enum memctl_state_t (IDLE, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT, RESP);
  - LINE_W and LINE_OFFSET_BITS=4;
  - a line_align function.
- No sub-module is needed. The timeout counter stays inline under the macro.

Test Plan:
- Clean miss: req_addr=0x104, dirty=0, memory model N=10, mem[0x100..0x10F]=0xDEADBEEF_...
  - Required: one mem_read_en pulse with mem_addr=0x100.
  - Required: fill_valid exactly 13 edges after accept, fill_addr=0x100, data matches.
- Dirty miss: victim 0x200 carrying 0x1111_2222_3333_4444_..., miss 0x300.
  - Required: write pulse to 0x200 first, then read pulse to 0x300; never both enables together.
  - Required: memory at 0x200 updated; fill_valid 25 edges after accept.
- Hold check: during WAIT, cache changes req_* inputs.
  - Required: mem_addr and mem_write_data unchanged until mem_ready; enables stay 0.
- Reset mid RD_WAIT: reset=0 for one cycle.
  - Required: FSM in IDLE, all outputs 0 next cycle, no fill_valid, req_ready=1.
- Spurious mem_ready in IDLE, and req_valid held high across RESP.
  - Required: spurious ready is ignored.
  - Required: second request accepted only after one IDLE cycle.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=64, memory never responds.
  - Required: mem_err=1 after 64 WAIT cycles, fill_valid with fill_data=0, mem_err remains 1 until reset.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and helpers for the data-cache memory-side controller.
package dcache_pkg;

   localparam int LINE_W           = 128;
   localparam int LINE_OFFSET_BITS = 4;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WB_REQ  = 3'd1,
      WB_WAIT = 3'd2,
      RD_REQ  = 3'd3,
      RD_WAIT = 3'd4,
      RESP    = 3'd5
   } memctl_state_t;

   // Clear the byte-within-line bits of an address (zero-extended to 64 bits).
   function automatic logic [63:0] line_align(input logic [63:0] addr);
      return {addr[63:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
   endfunction

endpackage

// File: rtl/dcache_mem_ctrl.sv
// Memory-side initiator for the data cache: optional victim write-back,
// then line fetch, then a one-cycle fill strobe back to the cache.
// Build option: define MEM_TIMEOUT_EN to add a per-transaction watchdog
// that raises the sticky mem_err flag and returns an all-zero fill.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | req_ready high, waiting for a miss
// WB_REQ  | one-cycle write pulse of the victim line
// WB_WAIT | victim address/data held until mem_ready
// RD_REQ  | one-cycle read pulse of the missing line
// RD_WAIT | miss address held until mem_ready, then capture read data
// RESP    | one-cycle fill_valid strobe to the cache
module dcache_mem_ctrl #(
   parameter int ADDR_W         = 32,
   parameter int LINE_W         = dcache_pkg::LINE_W,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_dirty,
   input  logic [ADDR_W-1:0] req_victim_addr,
   input  logic [LINE_W-1:0] req_victim_data,
   output logic              fill_valid,
   output logic [ADDR_W-1:0] fill_addr,
   output logic [LINE_W-1:0] fill_data,
   output logic              mem_read_en,
   output logic              mem_write_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_write_data,
   input  logic [LINE_W-1:0] mem_read_data,
   input  logic              mem_ready,
   output logic              mem_err
);

   import dcache_pkg::*;

   memctl_state_t     state;
   logic [ADDR_W-1:0] lat_addr;

   function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
      return ADDR_W'(line_align(64'(a)));
   endfunction

`ifdef MEM_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

   // Down-counter reloaded on entry to a WAIT state; terminal count at zero.
   logic [TMO_W-1:0] tmo_cnt;
   logic             mem_err_q;

   assign mem_err = mem_err_q;
`else
   assign mem_err = 1'b0;
`endif

   // Only IDLE accepts; derived straight from the state flop so it is glitch-free.
   assign req_ready = (state == IDLE);

   // Sequencer: state register and all registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= IDLE;
         lat_addr       <= '0;
         mem_read_en    <= 1'b0;
         mem_write_en   <= 1'b0;
         mem_addr       <= '0;
         mem_write_data <= '0;
         fill_valid     <= 1'b0;
         fill_addr      <= '0;
         fill_data      <= '0;
`ifdef MEM_TIMEOUT_EN
         tmo_cnt        <= '0;
         mem_err_q      <= 1'b0;
`endif
      end else begin
         // Enables and the fill strobe are single-cycle pulses by default.
         mem_read_en  <= 1'b0;
         mem_write_en <= 1'b0;
         fill_valid   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_addr <= align(req_addr);
                  if (req_dirty) begin
                     state          <= WB_REQ;
                     mem_write_en   <= 1'b1;
                     mem_addr       <= align(req_victim_addr);
                     mem_write_data <= req_victim_data;
                  end else begin
                     state       <= RD_REQ;
                     mem_read_en <= 1'b1;
                     mem_addr    <= align(req_addr);
                  end
               end
            end
            WB_REQ: begin
               state <= WB_WAIT;
`ifdef MEM_TIMEOUT_EN
               tmo_cnt <= TMO_LOAD;
`endif
            end
            WB_WAIT: begin
               // The memory samples address/data late; they stay put until ready.
               if (mem_ready) begin
                  state       <= RD_REQ;
                  mem_read_en <= 1'b1;
                  mem_addr    <= lat_addr;
               end
`ifdef MEM_TIMEOUT_EN
               else if (tmo_cnt == '0) begin
                  mem_err_q  <= 1'b1;
                  state      <= RESP;
                  fill_valid <= 1'b1;
                  fill_addr  <= lat_addr;
                  fill_data  <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt - 1'b1;
               end
`endif
            end
            RD_REQ: begin
               state <= RD_WAIT;
`ifdef MEM_TIMEOUT_EN
               tmo_cnt <= TMO_LOAD;
`endif
            end
            RD_WAIT: begin
               if (mem_ready) begin
                  state      <= RESP;
                  fill_valid <= 1'b1;
                  fill_addr  <= lat_addr;
                  fill_data  <= mem_read_data;
               end
`ifdef MEM_TIMEOUT_EN
               else if (tmo_cnt == '0) begin
                  mem_err_q  <= 1'b1;
                  state      <= RESP;
                  fill_valid <= 1'b1;
                  fill_addr  <= lat_addr;
                  fill_data  <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt - 1'b1;
               end
`endif
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Bench for dcache_mem_ctrl: latency-programmable line memory with late
// address/data sampling, transaction-level reference memory, directed and
// randomized misses.
module tb_dcache_mem_ctrl;

   localparam int N_STD = 10;
   localparam int TMO   = 64;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [31:0]   req_addr = '0;
   logic          req_dirty = 1'b0;
   logic [31:0]   req_victim_addr = '0;
   logic [127:0]  req_victim_data = '0;
   logic          fill_valid;
   logic [31:0]   fill_addr;
   logic [127:0]  fill_data;
   logic          mem_read_en;
   logic          mem_write_en;
   logic [31:0]   mem_addr;
   logic [127:0]  mem_write_data;
   logic [127:0]  mem_read_data;
   logic          mem_ready;
   logic          mem_err;

   always #5 clk = ~clk;

   dcache_mem_ctrl #(.ADDR_W(32), .LINE_W(128), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_dirty(req_dirty), .req_victim_addr(req_victim_addr),
      .req_victim_data(req_victim_data),
      .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
      .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
      .mem_ready(mem_ready), .mem_err(mem_err)
   );

   int n_cmp = 0;
   int n_mis = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] init_line(input logic [31:0] a);
      return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'd1};
   endfunction

   // Memory device: ready pulses mem_lat cycles after an enable is sampled;
   // address and write data are sampled only at that late point.
   logic [127:0] mem_q   [logic [31:0]];
   logic [127:0] ref_mem [logic [31:0]];
   int           mem_lat = N_STD;
   bit           mem_mute = 1'b0;
   bit           spur = 1'b0;
   int           m_cnt = 0;
   logic         m_rdy = 1'b0;
   logic [127:0] m_rdata = '0;
   logic         m_wr = 1'b0;
   logic [31:0]  m_addr = '0;
   logic [127:0] m_data = '0;
   bit           hold_err = 1'b0;
   bit           retrig_err = 1'b0;

   assign mem_ready     = m_rdy | spur;
   assign mem_read_data = m_rdata;

   always @(posedge clk) begin
      m_rdy <= 1'b0;
      if (m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            m_rdy <= 1'b1;
            if (mem_addr !== m_addr || (m_wr && mem_write_data !== m_data)) hold_err = 1'b1;
            if (m_wr) mem_q[mem_addr] = mem_write_data;
            else m_rdata <= mem_q.exists(mem_addr) ? mem_q[mem_addr] : init_line(mem_addr);
         end
      end
      if ((mem_read_en || mem_write_en) && !mem_mute) begin
         if (m_cnt > 0) retrig_err = 1'b1;
         m_cnt  <= mem_lat;
         m_wr   <= mem_write_en;
         m_addr <= mem_addr;
         m_data <= mem_write_data;
      end
   end

   // Port monitor, sampled on the falling edge.
   int           n_rd, n_wr, n_fv, rd_cyc, wr_cyc;
   logic [31:0]  rd_addr, wr_addr;
   logic [127:0] wr_data;
   bit           both_en;

   always @(negedge clk) begin
      if (mem_read_en) begin n_rd++; rd_addr = mem_addr; rd_cyc = cyc; end
      if (mem_write_en) begin n_wr++; wr_addr = mem_addr; wr_data = mem_write_data; wr_cyc = cyc; end
      if (mem_read_en && mem_write_en) both_en = 1'b1;
      if (fill_valid) n_fv++;
   end

   task automatic clr_mon();
      n_rd = 0; n_wr = 0; n_fv = 0; rd_cyc = 0; wr_cyc = 0;
      rd_addr = '0; wr_addr = '0; wr_data = '0; both_en = 1'b0;
      hold_err = 1'b0; retrig_err = 1'b0;
   endtask

   int last_fill = 0;
   int last_acc = 0;

   // Call at a falling edge; returns the accept edge number.
   task automatic start_req(input logic [31:0] a, input logic d, input logic [31:0] va,
                            input logic [127:0] vd, output int acc);
      int t;
      t = 0;
      while (!req_ready && t < 100) begin @(negedge clk); t++; end
      chk("req_ready_idle", req_ready, 1'b1);
      req_valid = 1'b1; req_addr = a; req_dirty = d;
      req_victim_addr = va; req_victim_data = vd;
      @(posedge clk); #1;
      acc = cyc;
      clr_mon();
   endtask

   task automatic do_txn(input logic [31:0] a, input logic d, input logic [31:0] va,
                         input logic [127:0] vd, input int n, input bit scramble,
                         input bit keep_valid);
      int acc, t, lat;
      logic [31:0] la, lva;
      logic [127:0] exp;
      mem_lat = n;
      la  = a & ~32'hF;
      lva = va & ~32'hF;
      start_req(a, d, va, vd, acc);
      last_acc = acc;
      if (!keep_valid) req_valid = 1'b0;
      // Reference: write-back lands before the fetch reads the line.
      if (d) ref_mem[lva] = vd;
      exp = ref_mem.exists(la) ? ref_mem[la] : init_line(la);
      lat = d ? 2 * n + 5 : n + 3;
      t = 0;
      @(negedge clk);
      while (!fill_valid && t < 300) begin
         if (scramble) begin
            req_addr = $urandom; req_dirty = 1'($urandom);
            req_victim_addr = $urandom;
            req_victim_data = {$urandom, $urandom, $urandom, $urandom};
         end
         @(negedge clk); t++;
      end
      chk("fill_seen", fill_valid, 1'b1);
      // Latency counted to the edge at which the cache samples the strobe.
      chk("fill_latency", cyc + 1 - acc, lat);
      chk("fill_addr", fill_addr, la);
      chk("fill_data", fill_data, exp);
      chk("req_ready_in_resp", req_ready, 1'b0);
      chk("rd_pulses", n_rd, 1);
      chk("rd_addr", rd_addr, la);
      chk("wr_pulses", n_wr, d);
      if (d) begin
         chk("wr_addr", wr_addr, lva);
         chk("wr_data", wr_data, vd);
         chk("wr_before_rd", wr_cyc < rd_cyc, 1'b1);
      end
      chk("both_en", both_en, 1'b0);
      chk("hold_stable", hold_err, 1'b0);
      chk("en_in_wait", retrig_err, 1'b0);
      last_fill = cyc;
      @(negedge clk);
      chk("fill_one_cycle", fill_valid, 1'b0);
      chk("fill_data_held", fill_data, exp);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, prev_fill, t;
      logic [127:0] vd;
      logic [31:0] a, va;
      bit d;

      repeat (3) @(negedge clk);
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_fill_valid", fill_valid, 1'b0);
      chk("rst_rd_en", mem_read_en, 1'b0);
      chk("rst_wr_en", mem_write_en, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_wdata", mem_write_data, 128'h0);
      chk("rst_fill_data", fill_data, 128'h0);
      chk("rst_mem_err", mem_err, 1'b0);
      reset = 1'b1;
      @(negedge clk);

      // Clean miss
      mem_q[32'h100]   = {4{32'hDEADBEEF}};
      ref_mem[32'h100] = {4{32'hDEADBEEF}};
      do_txn(32'h104, 1'b0, 32'h0, 128'h0, N_STD, 1'b0, 1'b0);

      // Dirty miss with the cache scrambling its request lines meanwhile
      vd = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
      do_txn(32'h300, 1'b1, 32'h200, vd, N_STD, 1'b1, 1'b0);
      chk("mem_writeback", mem_q.exists(32'h200) ? mem_q[32'h200] : 128'h0, vd);

      // Back-to-back with req_valid held across RESP
      do_txn(32'h80C, 1'b0, 32'h0, 128'h0, 4, 1'b0, 1'b1);
      prev_fill = last_fill;
      do_txn(32'h80C, 1'b0, 32'h0, 128'h0, 4, 1'b0, 1'b0);
      chk("b2b_gap", last_acc - prev_fill, 2);

      // Random misses over a small address window so lines get reused
      for (int i = 0; i < 16; i++) begin
         a  = $urandom_range(0, 32'hFFF);
         va = $urandom_range(0, 32'hFFF);
         d  = 1'($urandom);
         vd = {$urandom, $urandom, $urandom, $urandom};
         do_txn(a, d, va, vd, $urandom_range(1, 12), 1'b1, 1'b0);
      end

      // Reset in RD_WAIT
      mem_lat = N_STD;
      start_req(32'h540, 1'b0, 32'h0, 128'h0, acc);
      req_valid = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_req_ready", req_ready, 1'b1);
      chk("mid_rst_fill_valid", fill_valid, 1'b0);
      chk("mid_rst_rd_en", mem_read_en, 1'b0);
      chk("mid_rst_mem_addr", mem_addr, 32'h0);
      chk("mid_rst_fill_addr", fill_addr, 32'h0);
      chk("mid_rst_fill_data", fill_data, 128'h0);
      @(negedge clk);
      reset = 1'b1;
      clr_mon();
      // The memory still answers the aborted read here: a stray ready in IDLE.
      repeat (15) @(negedge clk);
      chk("post_rst_no_fill", n_fv, 0);
      chk("post_rst_no_en", n_rd + n_wr, 0);
      chk("post_rst_ready", req_ready, 1'b1);

      // Explicit spurious ready in IDLE
      clr_mon();
      spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
      repeat (3) @(negedge clk);
      chk("spur_no_fill", n_fv, 0);
      chk("spur_no_en", n_rd + n_wr, 0);
      chk("spur_ready", req_ready, 1'b1);
      do_txn(32'h9A0, 1'b1, 32'h9A0, {4{32'hCAFE_F00D}}, 3, 1'b0, 1'b0);
      chk("no_err", mem_err, 1'b0);

`ifdef MEM_TIMEOUT_EN
      mem_mute = 1'b1;
      start_req(32'h708, 1'b0, 32'h0, 128'h0, acc);
      req_valid = 1'b0;
      t = 0;
      @(negedge clk);
      while (!fill_valid && t < 200) begin @(negedge clk); t++; end
      chk("tmo_fill_seen", fill_valid, 1'b1);
      chk("tmo_latency", cyc - acc, TMO + 1);
      chk("tmo_err", mem_err, 1'b1);
      chk("tmo_fill_data", fill_data, 128'h0);
      chk("tmo_fill_addr", fill_addr, 32'h700);
      repeat (10) @(negedge clk);
      chk("tmo_err_sticky", mem_err, 1'b1);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("tmo_err_cleared", mem_err, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      mem_mute = 1'b0;
`endif

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
